// File: rtl/jk_reg_bank.sv
// WIDTH-bit register bank built from independent JK cells; LOAD, COUNT and SHIFT
// modes are expressed as per-bit J/K drives over the same storage.

module jk_cell #(
   parameter logic RV = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic j,
   input  logic k,
   output logic q
);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= RV;
      else if (en) begin
         case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end
endmodule

module jk_reg_bank #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] d,
   input  logic             dir,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic             tc,
   output logic             changed
);
   localparam logic [1:0] M_JK    = 2'b00;
   localparam logic [1:0] M_LOAD  = 2'b01;
   localparam logic [1:0] M_COUNT = 2'b10;
   localparam logic [1:0] M_SHIFT = 2'b11;

   logic [WIDTH-1:0] jj, kk, nxt, tgl, sh;
   logic             acc;

   assign sh = dir ? {sin, q[WIDTH-1:1]} : {q[WIDTH-2:0], sin};

   // Ripple toggle chain: bit i flips when every lower bit is 1 (up) or 0 (down).
   always_comb begin
      tgl = '0;
      acc = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         tgl[i] = acc;
         acc    = acc & (dir ? ~q[i] : q[i]);
      end
   end

   always_comb begin
      jj = j;
      kk = k;
      case (mode)
         M_JK:    begin jj = j;   kk = k;   end
         M_LOAD:  begin jj = d;   kk = ~d;  end
         M_COUNT: begin jj = tgl; kk = tgl; end
         M_SHIFT: begin jj = sh;  kk = ~sh; end
         default: begin jj = j;   kk = k;   end
      endcase
   end

   assign nxt = (jj & ~q) | (~kk & q);

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell #(.RV(RESET_VAL[i])) u_cell (
         .clk   (clk),
         .reset (reset),
         .en    (en),
         .j     (jj[i]),
         .k     (kk[i]),
         .q     (q[i])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) changed <= 1'b0;
      else       changed <= en & (nxt != q);
   end

   assign qn = ~q;
   assign tc = en & (mode == M_COUNT) & (dir ? (q == '0) : (q == {WIDTH{1'b1}}));
endmodule

// File: tb/tb_jk_reg_bank.sv
// Randomized and directed bench for jk_reg_bank (WIDTH=4, RESET_VAL=4'hA)
// against an arithmetic reference model of the register.

module tb_jk_reg_bank;
   localparam int         W  = 4;
   localparam logic [3:0] RV = 4'hA;

   logic         clk, reset, en, dir, sin;
   logic [1:0]   mode;
   logic [W-1:0] j, k, d;
   logic [W-1:0] q, qn;
   logic         tc, changed;

   int n_cmp = 0;
   int n_err = 0;

   logic [W-1:0] mq;       // model register
   logic         mchg;     // model changed flag
   logic [W-1:0] nq;       // model next value
   logic         nchg;
   logic         exp_tc;

   jk_reg_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k), .d(d),
      .dir(dir), .sin(sin), .q(q), .qn(qn), .tc(tc), .changed(changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] model_next(logic [W-1:0] cur, logic [1:0] m, logic dr,
                                               logic [W-1:0] jv, logic [W-1:0] kv,
                                               logic [W-1:0] dv, logic s);
      logic [W-1:0] r;
      r = cur;
      case (m)
         2'd0: for (int i = 0; i < W; i++) begin
                  if (jv[i] && kv[i])      r[i] = !cur[i];
                  else if (jv[i])          r[i] = 1'b1;
                  else if (kv[i])          r[i] = 1'b0;
               end
         2'd1: r = dv;
         2'd2: r = dr ? cur - 1'b1 : cur + 1'b1;
         default: r = dr ? {s, cur[W-1:1]} : {cur[W-2:0], s};
      endcase
      return r;
   endfunction

   // Drive inputs and derive what the model expects from the coming edge.
   task automatic apply(input logic e, input logic [1:0] m, input logic dr,
                        input logic [W-1:0] jv, input logic [W-1:0] kv,
                        input logic [W-1:0] dv, input logic s);
      en = e; mode = m; dir = dr; j = jv; k = kv; d = dv; sin = s;
      #1;
      nq     = e ? model_next(mq, m, dr, jv, kv, dv, s) : mq;
      nchg   = e && (nq != mq);
      exp_tc = e && (m == 2'd2) && (dr ? (mq == 4'h0) : (mq == 4'hF));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      mq   = nq;
      mchg = nchg;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      en = 1'b0; mode = 2'd0; dir = 1'b0; sin = 1'b0; j = '0; k = '0; d = '0;
      #2;
      n_cmp++; if (q !== RV)   begin n_err++; $display("FAIL reset_q got %h want %h", q, RV); end
      n_cmp++; if (qn !== 4'h5) begin n_err++; $display("FAIL reset_qn got %h want 5", qn); end
      n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL reset_changed got %b want 0", changed); end
      @(posedge clk); #3;
      reset = 1'b0;
      mq = RV; mchg = 1'b0;
      for (int n = 0; n < 3; n++) begin
         apply(1'b0, 2'($urandom_range(0, 3)), 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
         tick();
         n_cmp++; if (q !== RV) begin n_err++; $display("FAIL hold_after_reset got %h want %h", q, RV); end
         n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL hold_changed got %b want 0", changed); end
      end
   endtask

   task automatic test_jk();
      apply(1'b1, 2'd1, 1'b0, '0, '0, 4'b0101, 1'b0); tick();
      n_cmp++; if (q !== 4'b0101) begin n_err++; $display("FAIL jk_load got %b want 0101", q); end
      apply(1'b1, 2'd0, 1'b0, 4'b1100, 4'b1010, '0, 1'b0); tick();
      n_cmp++; if (q !== 4'b1101 || q !== mq) begin n_err++; $display("FAIL jk_mix got %b want 1101", q); end
      n_cmp++; if (changed !== 1'b1) begin n_err++; $display("FAIL jk_changed got %b want 1", changed); end
      apply(1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000, '0, 1'b0); tick();
      n_cmp++; if (q !== 4'b1101) begin n_err++; $display("FAIL jk_hold got %b want 1101", q); end
      n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL jk_hold_changed got %b want 0", changed); end
      apply(1'b1, 2'd0, 1'b0, 4'b1111, 4'b1111, '0, 1'b0); tick();
      n_cmp++; if (q !== 4'b0010) begin n_err++; $display("FAIL jk_invert got %b want 0010", q); end
   endtask

   task automatic test_count();
      logic [3:0] up_exp [3] = '{4'hF, 4'h0, 4'h1};
      logic       up_tc  [3] = '{1'b0, 1'b1, 1'b0};
      logic [3:0] dn_exp [2] = '{4'h0, 4'hF};
      logic       dn_tc  [2] = '{1'b0, 1'b1};
      apply(1'b1, 2'd1, 1'b0, '0, '0, 4'hE, 1'b0); tick();
      for (int n = 0; n < 3; n++) begin
         apply(1'b1, 2'd2, 1'b0, '0, '0, '0, 1'b0);
         n_cmp++; if (tc !== up_tc[n] || tc !== exp_tc) begin n_err++; $display("FAIL count_up_tc step %0d got %b want %b", n, tc, up_tc[n]); end
         tick();
         n_cmp++; if (q !== up_exp[n] || q !== mq) begin n_err++; $display("FAIL count_up step %0d got %h want %h", n, q, up_exp[n]); end
      end
      for (int n = 0; n < 2; n++) begin
         apply(1'b1, 2'd2, 1'b1, '0, '0, '0, 1'b0);
         n_cmp++; if (tc !== dn_tc[n]) begin n_err++; $display("FAIL count_dn_tc step %0d got %b want %b", n, tc, dn_tc[n]); end
         tick();
         n_cmp++; if (q !== dn_exp[n]) begin n_err++; $display("FAIL count_dn step %0d got %h want %h", n, q, dn_exp[n]); end
      end
   endtask

   task automatic test_shift();
      apply(1'b1, 2'd1, 1'b0, '0, '0, 4'b1001, 1'b0); tick();
      apply(1'b1, 2'd3, 1'b0, '0, '0, '0, 1'b1); tick();
      n_cmp++; if (q !== 4'b0011) begin n_err++; $display("FAIL shift_left got %b want 0011", q); end
      apply(1'b1, 2'd3, 1'b1, '0, '0, '0, 1'b0); tick();
      n_cmp++; if (q !== 4'b0001) begin n_err++; $display("FAIL shift_right0 got %b want 0001", q); end
      apply(1'b1, 2'd3, 1'b1, '0, '0, '0, 1'b1); tick();
      n_cmp++; if (q !== 4'b1000) begin n_err++; $display("FAIL shift_right1 got %b want 1000", q); end
   endtask

   task automatic test_enable();
      logic       ens  [3] = '{1'b1, 1'b0, 1'b1};
      logic [3:0] qexp [3] = '{4'h1, 4'h1, 4'h2};
      apply(1'b1, 2'd1, 1'b0, '0, '0, 4'h0, 1'b0); tick();
      for (int n = 0; n < 3; n++) begin
         apply(ens[n], 2'd2, 1'b0, '0, '0, '0, 1'b0);
         n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL enable_tc step %0d got %b want 0", n, tc); end
         tick();
         n_cmp++; if (q !== qexp[n]) begin n_err++; $display("FAIL enable_q step %0d got %h want %h", n, q, qexp[n]); end
         n_cmp++; if (changed !== ens[n]) begin n_err++; $display("FAIL enable_changed step %0d got %b want %b", n, changed, ens[n]); end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         apply(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 1'($urandom),
               4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
         n_cmp++; if (tc !== exp_tc) begin n_err++; $display("FAIL rand_tc iter %0d got %b want %b", n, tc, exp_tc); end
         tick();
         n_cmp++; if (q !== mq) begin n_err++; $display("FAIL rand_q iter %0d got %h want %h", n, q, mq); end
         n_cmp++; if (qn !== ~mq) begin n_err++; $display("FAIL rand_qn iter %0d got %h want %h", n, qn, ~mq); end
         n_cmp++; if (changed !== mchg) begin n_err++; $display("FAIL rand_changed iter %0d got %b want %b", n, changed, mchg); end
      end
   endtask

   task automatic test_reset_mid_count();
      apply(1'b1, 2'd1, 1'b0, '0, '0, 4'h0, 1'b0); tick();
      for (int n = 0; n < 6; n++) begin
         apply(1'b1, 2'd2, 1'b0, '0, '0, '0, 1'b0); tick();
      end
      n_cmp++; if (q !== 4'h6) begin n_err++; $display("FAIL midcount_pre got %h want 6", q); end
      #2 reset = 1'b1;
      #1;
      mq = RV; mchg = 1'b0;
      n_cmp++; if (q !== RV) begin n_err++; $display("FAIL midcount_async_q got %h want %h", q, RV); end
      n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL midcount_async_changed got %b want 0", changed); end
      // Release lands on the clock edge itself; the flops must still see reset there.
      @(posedge clk);
      reset <= 1'b0;
      #1;
      n_cmp++; if (q !== RV) begin n_err++; $display("FAIL release_edge got %h want %h", q, RV); end
      apply(1'b1, 2'd2, 1'b0, '0, '0, '0, 1'b0); tick();
      n_cmp++; if (q !== 4'hB) begin n_err++; $display("FAIL after_release got %h want b", q); end
      n_cmp++; if (changed !== 1'b1) begin n_err++; $display("FAIL after_release_changed got %b want 1", changed); end
   endtask

   initial begin
      test_reset();
      test_jk();
      test_count();
      test_shift();
      test_enable();
      test_random();
      test_reset_mid_count();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
